// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signals of the instruction cache responder.
// The slave modport is the cache; the master modport is the fetch stage plus backing memory.
interface icache_responder_if;
  logic [31:0] Instr_address_fIF;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] Instr_2IF;
  logic        hit;
  logic        stall_2IF;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output Instr_address_fIF, fetch_valid, flush, mem_rdata, mem_rvalid,
    input  Instr_2IF, hit, stall_2IF, mem_req, mem_addr
  );

  modport slave (
    input  Instr_address_fIF, fetch_valid, flush, mem_rdata, mem_rvalid,
    output Instr_2IF, hit, stall_2IF, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: combinational hit path, stalling line refill on a miss.
// Define ICACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module icache_responder #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input logic               CLK,
  input logic               RESET,
  icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned CW = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned OB = CW + 2;
  localparam int unsigned TW = 32 - OB - IB;

  typedef enum logic [1:0] {StIdle, StReq, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      line_q, line_d;
  logic             flushed_q, flushed_d;
  logic             mem_req_q, mem_req_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [31:0]      data_q [LINES][WORDS_PER_LINE];
  logic [TW-1:0]    tag_q  [LINES];

  logic [CW-1:0]    off;
  logic [IB-1:0]    idx, fill_idx;
  logic [TW-1:0]    tag, fill_tag;
  logic             lookup_hit;
  logic             beat;
  logic             unused_addr_lo;

  assign off            = bus.Instr_address_fIF[OB-1:2];
  assign idx            = bus.Instr_address_fIF[OB+IB-1:OB];
  assign tag            = bus.Instr_address_fIF[31:OB+IB];
  assign fill_idx       = line_q[OB+IB-1:OB];
  assign fill_tag       = line_q[31:OB+IB];
  assign unused_addr_lo = ^bus.Instr_address_fIF[1:0];

  assign lookup_hit = (state_q == StIdle) && bus.fetch_valid && valid_q[idx] &&
                      (tag_q[idx] == tag);
  assign beat       = bus.mem_rvalid && ((state_q == StReq) || (state_q == StFill));

  assign bus.hit       = lookup_hit;
  assign bus.Instr_2IF = lookup_hit ? data_q[idx][off] : 32'h0000_0000;
  // Gated by RESET so the fetch stage sees no stall while reset is held.
  assign bus.stall_2IF = RESET && ((state_q != StIdle) || (bus.fetch_valid && !lookup_hit));
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = line_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    mem_req_d = mem_req_q;
    flushed_d = flushed_q;
    valid_d   = valid_q;

    case (state_q)
      StIdle: begin
        if (bus.fetch_valid && !lookup_hit) begin
          line_d    = {bus.Instr_address_fIF[31:OB], {OB{1'b0}}};
          cnt_d     = '0;
          mem_req_d = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (bus.mem_rvalid) begin
          mem_req_d = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          state_d   = StFill;
        end
      end
      StFill: begin
        if (bus.mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WORDS_PER_LINE - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flush seen while a refill is in flight must keep that line invalid.
    if (state_q == StDone) begin
      flushed_d = 1'b0;
    end else if (bus.flush && (state_q != StIdle)) begin
      flushed_d = 1'b1;
    end

    if (bus.flush) begin
      valid_d = '0;
    end else if ((state_q == StDone) && !flushed_q) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      line_q    <= '0;
      mem_req_q <= 1'b0;
      flushed_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      mem_req_q <= mem_req_d;
      flushed_q <= flushed_d;
      valid_q   <= valid_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge CLK) begin
    if (beat) data_q[fill_idx][cnt_q] <= bus.mem_rdata;
    if (state_q == StDone) tag_q[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit) hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == StIdle) && (state_d == StReq)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized bench for icache_responder against a line-level cache model.
// Statistics outputs are checked when ICACHE_STATS_EN is defined.
module tb_icache_responder;
  localparam int unsigned LINES = 16;
  localparam int unsigned WPL   = 4;
  localparam int unsigned LB    = WPL * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  icache_responder_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_responder #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES][WPL];
  int unsigned m_hits, m_misses;
  logic [31:0] beat_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valid();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int b);
    return ((line + 32'(b) * 4) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned ln;
    ln = a / LB;
    return m_valid[ln % LINES] && (m_tag[ln % LINES] == ln / LINES);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned ln;
    ln = a / LB;
    return m_data[ln % LINES][(a % LB) / 4];
  endfunction

  task automatic stats_check(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, m_hits);
    check({tag, "_miss_count"}, miss_count, m_misses);
`endif
  endtask

  // Starts in the REQ cycle. fb = beat carrying a flush; fb == WPL flushes in DONE.
  task automatic refill(input logic [31:0] a, input int gap, input int fb);
    logic [31:0] line;
    int unsigned idx;
    bit          flushed;
    logic [31:0] w [WPL];
    line    = a - (a % LB);
    idx     = (a / LB) % LINES;
    flushed = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.flush      = 1'b0;
    #3;
    check("req_mem_req", bus.mem_req, 1);
    check("req_mem_addr", bus.mem_addr, line);
    check("req_stall", bus.stall_2IF, 1);
    check("req_instr", bus.Instr_2IF, 0);
    for (int b = 0; b < WPL; b++) begin
      for (int g = 0; g < gap; g++) begin
        bus.mem_rvalid        = 1'b0;
        bus.mem_rdata         = $urandom;
        bus.Instr_address_fIF = $urandom;
        bus.fetch_valid       = 1'($urandom_range(0, 1));
        #3;
        check("gap_mem_req", bus.mem_req, (b == 0) ? 1 : 0);
        check("gap_stall", bus.stall_2IF, 1);
        tick();
      end
      w[b] = (beat_q.size() != 0) ? beat_q.pop_front() : mem_word(line, b);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = w[b];
      bus.flush      = (b == fb);
      #3;
      check("beat_mem_req", bus.mem_req, (b == 0) ? 1 : 0);
      check("beat_hit", bus.hit, 0);
      tick();
      if (b == fb) flushed = 1'b1;
      bus.flush      = 1'b0;
      bus.mem_rvalid = 1'b0;
    end
    bus.flush = (fb == WPL);
    #3;
    check("done_stall", bus.stall_2IF, 1);
    check("done_mem_req", bus.mem_req, 0);
    tick();
    if (fb == WPL) flushed = 1'b1;
    bus.flush = 1'b0;
    m_tag[idx] = (a / LB) / LINES;
    for (int b = 0; b < WPL; b++) m_data[idx][b] = w[b];
    if (flushed) clear_valid();
    else m_valid[idx] = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input int gap, input int fb);
    bit done;
    bit exp_hit;
    done = 1'b0;
    for (int attempt = 0; attempt < 3 && !done; attempt++) begin
      bus.Instr_address_fIF = a;
      bus.fetch_valid       = 1'b1;
      bus.flush             = 1'b0;
      bus.mem_rvalid        = 1'($urandom_range(0, 1));
      bus.mem_rdata         = $urandom;
      exp_hit               = model_hit(a);
      #3;
      check("lookup_hit", bus.hit, exp_hit);
      check("lookup_stall", bus.stall_2IF, !exp_hit);
      check("lookup_instr", bus.Instr_2IF, exp_hit ? model_word(a) : 32'h0);
      tick();
      if (exp_hit) begin
        m_hits++;
        done = 1'b1;
      end else begin
        m_misses++;
        refill(a, gap, (attempt == 0) ? fb : -1);
      end
    end
    check("fetch_completed", done, 1);
  endtask

  task automatic idle_cycle(input logic [31:0] a, input bit do_flush);
    bit exp_hit;
    exp_hit               = model_hit(a);
    bus.Instr_address_fIF = a;
    bus.fetch_valid       = exp_hit;
    bus.flush             = do_flush;
    bus.mem_rvalid        = 1'($urandom_range(0, 1));
    bus.mem_rdata         = $urandom;
    #3;
    check("idle_hit", bus.hit, exp_hit);
    check("idle_stall", bus.stall_2IF, 0);
    check("idle_instr", bus.Instr_2IF, exp_hit ? model_word(a) : 32'h0);
    tick();
    if (exp_hit) m_hits++;
    if (do_flush) clear_valid();
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          fb;
    clear_valid();
    m_hits   = 0;
    m_misses = 0;
    bus.Instr_address_fIF = 32'h40;
    bus.fetch_valid       = 1'b1;
    bus.flush             = 1'b0;
    bus.mem_rdata         = '0;
    bus.mem_rvalid        = 1'b0;

    repeat (2) @(posedge clk);
    #3;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_stall", bus.stall_2IF, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_instr", bus.Instr_2IF, 0);
    tick();
    rst_n = 1'b1;
    stats_check("after_reset");

    beat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    fetch(32'h40, 0, -1);
    fetch(32'h44, 0, -1);
    fetch(32'h48, 0, -1);
    fetch(32'h4C, 0, -1);
    fetch(32'h4F, 0, -1);
    check("same_line_word", model_word(32'h4F), 32'h44);
    stats_check("cold_then_hits");

    beat_q = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
    fetch(32'h140, 0, -1);
    fetch(32'h40, 1, -1);
    fetch(32'h80, 2, 2);

    idle_cycle(32'h40, 1'b1);
    stats_check("after_idle_flush");

    // Abandon a refill with an asynchronous reset in FILL.
    bus.Instr_address_fIF = 32'h80;
    bus.fetch_valid       = 1'b1;
    #3;
    check("rmid_miss_stall", bus.stall_2IF, 1);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1;
    tick();
    bus.mem_rdata = 32'h2;
    tick();
    rst_n = 1'b0;
    #2;
    check("rmid_mem_req", bus.mem_req, 0);
    check("rmid_mem_addr", bus.mem_addr, 0);
    check("rmid_stall", bus.stall_2IF, 0);
    check("rmid_hit", bus.hit, 0);
    check("rmid_instr", bus.Instr_2IF, 0);
    clear_valid();
    m_hits   = 0;
    m_misses = 0;
    tick();
    rst_n           = 1'b1;
    bus.fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rdata = $urandom;
      #3;
      check("stray_mem_req", bus.mem_req, 0);
      check("stray_stall", bus.stall_2IF, 0);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    fetch(32'h80, 0, -1);
    fetch(32'h0, 0, -1);
    bus.fetch_valid = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'hDEAD_BEEF;
    #3;
    check("stray_idle_stall", bus.stall_2IF, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    fetch(32'h0, 0, -1);
    stats_check("after_reset_mid_refill");

    for (int it = 0; it < 250; it++) begin
      a = ($urandom_range(0, 3) * LINES + $urandom_range(0, LINES - 1)) * LB +
          $urandom_range(0, LB - 1);
      case ($urandom_range(0, 19))
        0:       idle_cycle(a, 1'b0);
        1:       idle_cycle(a, 1'b1);
        default: begin
          fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WPL)) : -1;
          fetch(a, int'($urandom_range(0, 2)), fb);
        end
      endcase
    end
    stats_check("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
